// File: rtl/ecc_61_enc_wr_if.sv
// ============================================================================
// Module  : ecc_61_enc_wr_if
// Brief   : Upstream word / downstream codeword handshake bundle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ecc_61_enc_wr_if #(
   parameter int DATA_WIDTH   = 61,
   parameter int PARITY_WIDTH = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_WIDTH-1:0]   in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_WIDTH-1:0]   out_data;
   logic [PARITY_WIDTH-1:0] out_parity;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_parity
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_parity
   );
endinterface

`default_nettype wire

// File: rtl/ecc_61_enc_wr.sv
// ============================================================================
// Module  : ecc_61_enc_wr
// Brief   : 61-bit SECDED write-side encoder with 2-entry skid buffer.
//           Optional error injection enabled by macro ECC_ERR_INJ_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ecc_61_enc_wr #(
   parameter int DATA_WIDTH   = 61,
   parameter int PARITY_WIDTH = 8,
   parameter int CNT_WIDTH    = 16
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   ecc_61_enc_wr_if.slave            bus,
`ifdef ECC_ERR_INJ_EN
   input  wire logic                 inj_req,
   input  wire logic                 inj_dbl,
   input  wire logic [5:0]           inj_pos,
   output logic                      inj_done,
`endif
   output logic [CNT_WIDTH-1:0]      enc_cnt
);

   localparam int c_cw_w = DATA_WIDTH + PARITY_WIDTH;

   // H-matrix column for data bit idx: low 7 bits walk the non-power-of-two
   // integers from 3 upward, top bit forces odd column weight.
   function automatic logic [7:0] f_col(input int idx);
      logic [7:0] r;
      logic [6:0] low;
      int         n;
      r   = '0;
      low = '0;
      n   = 0;
      for (int v = 3; v < 70; v++) begin
         if ((v & (v - 1)) != 0) begin
            if (n == idx) begin
               low = v[6:0];
               r   = {~(^low), low};
            end
            n++;
         end
      end
      return r;
   endfunction

   logic [PARITY_WIDTH-1:0] w_parity;
   logic [DATA_WIDTH-1:0]   w_store_data;
   logic [c_cw_w-1:0]       w_word;
   logic                    w_accept;
   logic                    w_drain;
   logic                    w_skid_v_nxt;

   logic                    r_in_ready;
   logic                    r_main_v;
   logic [c_cw_w-1:0]       r_main_q;
   logic                    r_skid_v;
   logic [c_cw_w-1:0]       r_skid_q;
   logic [CNT_WIDTH-1:0]    r_cnt;

   always_comb begin
      w_parity = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (bus.in_data[i]) begin
            w_parity = w_parity ^ f_col(i);
         end
      end
   end

   assign w_accept = bus.in_valid & r_in_ready;
   assign w_drain  = r_main_v & bus.out_ready;
   assign w_word   = {w_parity, w_store_data};

   // Skid only fills when main is held; accept with a full skid is impossible.
   assign w_skid_v_nxt = w_drain ? 1'b0 : (r_skid_v | (w_accept & r_main_v));

`ifdef ECC_ERR_INJ_EN
   logic       r_inj_pend;
   logic       r_inj_dbl;
   logic [5:0] r_inj_pos;
   logic       r_inj_done;
   logic [5:0] w_pos0;
   logic [5:0] w_pos1;
   logic [DATA_WIDTH-1:0] w_mask;

   always_comb begin
      w_pos0 = (r_inj_pos > 6'd60) ? 6'd0 : r_inj_pos;
      w_pos1 = (w_pos0 == 6'd60) ? 6'd0 : w_pos0 + 6'd1;
      w_mask = '0;
      if (r_inj_pend) begin
         w_mask[w_pos0] = 1'b1;
         if (r_inj_dbl) begin
            w_mask[w_pos1] = 1'b1;
         end
      end
   end

   // Parity above uses the original data; only the stored data is corrupted.
   assign w_store_data = bus.in_data ^ w_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inj_pend <= 1'b0;
         r_inj_dbl  <= 1'b0;
         r_inj_pos  <= 6'd0;
         r_inj_done <= 1'b0;
      end else begin
         r_inj_done <= w_accept & r_inj_pend;
         if (w_accept & r_inj_pend) begin
            r_inj_pend <= 1'b0;
         end
         if (inj_req) begin
            r_inj_pend <= 1'b1;
            r_inj_dbl  <= inj_dbl;
            r_inj_pos  <= inj_pos;
         end
      end
   end

   assign inj_done = r_inj_done;
`else
   assign w_store_data = bus.in_data;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_ready <= 1'b0;
         r_main_v   <= 1'b0;
         r_main_q   <= '0;
         r_skid_v   <= 1'b0;
         r_skid_q   <= '0;
      end else begin
         r_in_ready <= ~w_skid_v_nxt;
         r_skid_v   <= w_skid_v_nxt;
         if (w_drain) begin
            if (r_skid_v) begin
               r_main_q <= r_skid_q;
            end else if (w_accept) begin
               r_main_q <= w_word;
            end else begin
               r_main_v <= 1'b0;
            end
         end else if (w_accept) begin
            if (!r_main_v) begin
               r_main_v <= 1'b1;
               r_main_q <= w_word;
            end else begin
               r_skid_q <= w_word;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_accept && (r_cnt != {CNT_WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.out_valid  = r_main_v;
   assign bus.out_data   = r_main_q[DATA_WIDTH-1:0];
   assign bus.out_parity = r_main_q[c_cw_w-1:DATA_WIDTH];
   assign enc_cnt        = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ecc_61_enc_wr.sv
// ============================================================================
// Module  : tb_ecc_61_enc_wr
// Brief   : Scoreboard bench for ecc_61_enc_wr (default and 4-bit counter).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ecc_61_enc_wr;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ecc_61_enc_wr_if #(.DATA_WIDTH(61), .PARITY_WIDTH(8)) bus ();
   ecc_61_enc_wr_if #(.DATA_WIDTH(61), .PARITY_WIDTH(8)) bus4 ();

   logic [15:0] enc_cnt;
   logic [3:0]  enc_cnt4;

   assign bus4.in_valid  = bus.in_valid;
   assign bus4.in_data   = bus.in_data;
   assign bus4.out_ready = bus.out_ready;

`ifdef ECC_ERR_INJ_EN
   logic       inj_req = 1'b0;
   logic       inj_dbl = 1'b0;
   logic [5:0] inj_pos = 6'd0;
   logic       inj_done;
   logic       inj_done4;
`endif

   ecc_61_enc_wr #(.DATA_WIDTH(61), .PARITY_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
`ifdef ECC_ERR_INJ_EN
      .inj_req  (inj_req),
      .inj_dbl  (inj_dbl),
      .inj_pos  (inj_pos),
      .inj_done (inj_done),
`endif
      .enc_cnt  (enc_cnt)
   );

   ecc_61_enc_wr #(.DATA_WIDTH(61), .PARITY_WIDTH(8), .CNT_WIDTH(4)) dut4 (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus4.slave),
`ifdef ECC_ERR_INJ_EN
      .inj_req  (inj_req),
      .inj_dbl  (inj_dbl),
      .inj_pos  (inj_pos),
      .inj_done (inj_done4),
`endif
      .enc_cnt  (enc_cnt4)
   );

   logic [68:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          inj_pulses = 0;
   logic [60:0] tbl_d[11];
   logic [7:0]  tbl_p[11];

   task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Pops on output transfer; while stalled compares against the head, which
   // also proves the outputs hold stable.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got %h expected none", {bus.out_parity, bus.out_data});
            end else begin
               chk("codeword", {bus.out_parity, bus.out_data}, exp_q[0]);
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
      end
   endtask

   task automatic inj_mon();
      forever begin
         @(negedge clk);
`ifdef ECC_ERR_INJ_EN
         if (inj_done) inj_pulses++;
`endif
      end
   endtask

   task automatic send(input logic [60:0] d, input logic [68:0] exp, output int waited);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      waited = 0;
      while (1) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(exp);
            @(posedge clk);
            #1;
            break;
         end
         waited++;
         if (waited > 100) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", waited);
            break;
         end
      end
   endtask

   task automatic drain();
      int n;
      bus.in_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      chk("drained", {68'd0, exp_q.size() == 0 && !bus.out_valid}, 69'd1);
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1);
   end

   initial begin
      int w;
      logic [60:0] a, b, c;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      tbl_d[0] = 61'd0;                          tbl_p[0]  = 8'h00;
      tbl_d[1] = 61'd1;                          tbl_p[1]  = 8'h83;
      tbl_d[2] = 61'd8;                          tbl_p[2]  = 8'h07;
      tbl_d[3] = 61'd1 << 60;                    tbl_p[3]  = 8'hC4;
      tbl_d[4] = 61'd9;                          tbl_p[4]  = 8'h84;
      tbl_d[5] = (61'd1 << 60) | 61'd1;          tbl_p[5]  = 8'h47;
      tbl_d[6] = (61'd1 << 60) | 61'd8;          tbl_p[6]  = 8'hC3;
      tbl_d[7] = (61'd1 << 60) | 61'd9;          tbl_p[7]  = 8'h40;
      tbl_d[8] = 61'd2;                          tbl_p[8]  = 8'h85;
      tbl_d[9] = 61'd4;                          tbl_p[9]  = 8'h86;
      tbl_d[10] = 61'd16;                        tbl_p[10] = 8'h89;
      fork
         monitor();
         inj_mon();
      join_none

      // Reset values while held
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  {68'd0, bus.in_ready}, 69'd0);
      chk("rst_out_valid", {68'd0, bus.out_valid}, 69'd0);
      chk("rst_out_word",  {bus.out_parity, bus.out_data}, 69'd0);
      chk("rst_enc_cnt",   {53'd0, enc_cnt}, 69'd0);
      rst = 1'b0;
      chk("rel_in_ready_low", {68'd0, bus.in_ready}, 69'd0);
      @(posedge clk);
      #1;
      chk("rel_in_ready", {68'd1 & 68'd0, bus.in_ready}, 69'd1);

      // First word, latency 1
      bus.out_ready = 1'b1;
      send(tbl_d[0], {tbl_p[0], tbl_d[0]}, w);
      bus.in_valid = 1'b0;
      chk("lat_out_valid", {68'd0, bus.out_valid}, 69'd1);
      chk("lat_enc_cnt", {53'd0, enc_cnt}, 69'd1);
      drain();

      // Single-hot words back to back at full rate
      for (int i = 1; i <= 3; i++) begin
         send(tbl_d[i], {tbl_p[i], tbl_d[i]}, w);
         chk("full_rate_wait", 69'(w), 69'd0);
      end
      drain();

      // Stall: A and B fill both entries, C held off
      a = tbl_d[4]; b = tbl_d[5]; c = tbl_d[7];
      bus.out_ready = 1'b0;
      send(a, {tbl_p[4], a}, w);
      send(b, {tbl_p[5], b}, w);
      chk("stall_in_ready", {68'd0, bus.in_ready}, 69'd0);
      fork
         begin
            send(c, {tbl_p[7], c}, w);
            chk("stall_c_held", {68'd0, w >= 3}, 69'd1);
         end
         begin
            repeat (4) @(posedge clk);
            #1 bus.out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("no_gap", {68'd0, bus.out_valid}, 69'd1);
            end
         end
      join
      drain();

      // Reset with both entries full
      bus.out_ready = 1'b0;
      send(tbl_d[6], {tbl_p[6], tbl_d[6]}, w);
      send(tbl_d[8], {tbl_p[8], tbl_d[8]}, w);
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("midrst_out_valid", {68'd0, bus.out_valid}, 69'd0);
      chk("midrst_enc_cnt", {53'd0, enc_cnt}, 69'd0);
      chk("midrst_in_ready", {68'd0, bus.in_ready}, 69'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("postrst_in_ready", {68'd0, bus.in_ready}, 69'd1);
      bus.out_ready = 1'b1;
      send(tbl_d[9], {tbl_p[9], tbl_d[9]}, w);
      drain();

      // Counter saturation on the 4-bit instance
      do_reset();
      for (int i = 0; i < 20; i++) begin
         send(tbl_d[i % 11], {tbl_p[i % 11], tbl_d[i % 11]}, w);
         if (i == 13) chk("cnt4_at14", {65'd0, enc_cnt4}, 69'hE);
         if (i == 14) chk("cnt4_at15", {65'd0, enc_cnt4}, 69'hF);
      end
      bus.in_valid = 1'b0;
      chk("cnt4_sat", {65'd0, enc_cnt4}, 69'hF);
      chk("cnt16_20", {53'd0, enc_cnt}, 69'd20);
      drain();

`ifdef ECC_ERR_INJ_EN
      inj_pulses = 0;
      inj_req = 1'b1; inj_dbl = 1'b0; inj_pos = 6'd5;
      @(posedge clk);
      #1 inj_req = 1'b0;
      send(61'd0, {8'h00, 61'h20}, w);
      drain();
      chk("inj_sbit_pulses", 69'(inj_pulses), 69'd1);
      inj_pulses = 0;
      inj_req = 1'b1; inj_dbl = 1'b1; inj_pos = 6'd60;
      @(posedge clk);
      #1 inj_req = 1'b0;
      send(61'd0, {8'h00, (61'd1 << 60) | 61'd1}, w);
      send(tbl_d[1], {tbl_p[1], tbl_d[1]}, w);
      drain();
      chk("inj_dbit_pulses", 69'(inj_pulses), 69'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ecc_61_enc_wr.md
Name: ecc_61_enc_wr

Overview:
- Write-side SECDED encoder for the 61-bit FIFO datapath. It is the producer of codewords that the 61-bit ECC checker decodes on the read side.
- Accepts 61-bit data on a valid/ready interface and computes the 8-bit parity.
- Presents a registered {parity, data} codeword to the FIFO write port through a 2-entry skid buffer. Full throughput with a registered in_ready.

Parameters:
- DATA_WIDTH, 61, data bits per word; fixed, the H-matrix is defined only for 61.
- PARITY_WIDTH, 8, parity bits per word; fixed.
- CNT_WIDTH, 16, width of the accepted-word counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream may transfer; registered
- in_data  in  61  data word to encode
- out_valid  out  1  codeword valid toward the FIFO write port
- out_ready  in  1  FIFO can accept a codeword
- out_data  out  61  data field of the codeword
- out_parity  out  8  parity field of the codeword
- enc_cnt  out  CNT_WIDTH  count of accepted words, saturating

Behaviour:
- Reset: all outputs and state reset asynchronously on rst=1; released synchronously to clk.
  - in_ready=0 while rst is asserted; in_ready=1 on the first clk edge after release.
  - out_valid=0, out_data=0, out_parity=0, enc_cnt=0, both skid entries empty.
- Transfers:
  - Input transfer when in_valid & in_ready at a clk edge.
  - Output transfer when out_valid & out_ready at a clk edge.
- Parity code, defined per data bit i:
  - Column low7(i) is the i-th integer ≥3 that is not a power of two: d0→3, d1→5, d2→6, d3→7, d4→9, …, d60→68.
  - p[k], k=0..6: XOR of all d[i] with bit k of low7(i) set.
  - p[7]: XOR of all d[i] whose low7(i) has even popcount. Every column therefore has odd weight.
  - Check values: d0 gives 8'h83; d3 gives 8'h07; d60 gives 8'hC4.
- Pipeline:
  - Parity is computed combinationally from in_data and registered together with the data into the skid buffer.
  - Latency is 1 cycle: a word accepted at edge N is visible on out_* after edge N, with out_valid=1 from then.
- Skid buffer:
  - Entries are main (drives out_*) and skid.
  - in_ready = skid entry empty, registered.
  - On accept with main empty, or main draining the same cycle, the word goes to main.
  - On accept with main occupied and not draining, the word goes to skid and in_ready drops next cycle.
  - On output transfer, skid moves to main if occupied.
  - A simultaneous accept and drain with both entries full cannot occur, because in_ready=0 when skid is occupied.
- Ordering is strictly FIFO; no word is dropped or duplicated.
- out_data and out_parity hold stable while out_valid=1 and out_ready=0.
- enc_cnt increments by 1 per input transfer and saturates at all-ones; it never wraps.
- in_data and in_valid are ignored when in_ready=0.
- A reset asserted mid-operation empties both entries immediately and discards any in-flight words.

Optional Feature:
- Macro: ECC_ERR_INJ_EN.
- When defined, the block adds these ports:
  - inj_req  in  1
  - inj_dbl  in  1  (0 = single-bit, 1 = double-bit)
  - inj_pos  in  6
  - inj_done  out  1  (reset 0)
- Arming: inj_req=1 arms a pending injection and latches inj_dbl and inj_pos. A new inj_req while an injection is pending overwrites the latched values.
- Application: the next accepted word has its parity computed on the original data. The stored data then has bit pos flipped, plus bit (pos==60 ? 0 : pos+1) when inj_dbl=1.
- inj_pos values above 60 are treated as 0.
- inj_done pulses for 1 cycle on the accepting edge, and pending clears.
- Reset clears pending.
- When the macro is not defined: no injection ports and no injection logic; codewords are always clean.

Test Plan:
- Reset, then out_ready=1 and in_data=61'h0 → one cycle later out_valid=1, out_parity=8'h00, enc_cnt=1.
- Single-hot data at bits 0, 3, 60, one per cycle → out_parity 8'h83, 8'h07, 8'hC4 on consecutive cycles, one word per cycle.
- out_ready=0, push words A, B, C back to back → A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready → A, B, C emerge in order with no gaps and out_* stable while stalled.
- Assert rst with both entries full → out_valid=0 and enc_cnt=0 immediately; after release, in_ready=1 and the next word emerges correctly.
- Set CNT_WIDTH=4 and push 20 words → enc_cnt stops at 4'hF.
- With ECC_ERR_INJ_EN: inj_req with inj_dbl=0 and inj_pos=5, then data 0 → out_data=61'h20, out_parity=8'h00, inj_done pulses once. Read-side checker reports sbit_err with syndrome 8'h8A.
- With ECC_ERR_INJ_EN: inj_req with inj_dbl=1 and inj_pos=60, then data 0 → bits 60 and 0 set, inj_done pulses once. Read-side checker reports dbit_err.
